// File: rtl/fp_round_pack_pipe.sv
// Two-stage IEEE-style round-and-pack pipeline: S1 picks the rounding increment and adds it
// to the fraction, S2 renormalises, range-checks, packs and registers the result.
module fp_round_pack_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W+1:0]          in_exp,
  input  logic [FRAC_W-1:0]         in_frac,
  input  logic                      in_guard,
  input  logic                      in_round,
  input  logic                      in_sticky,
  input  logic [1:0]                in_class,
  input  logic [1:0]                in_rmode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_data,
  output logic [2:0]                out_flags
);

  localparam int XW = EXP_W + 3;

  typedef enum logic [1:0] {CLS_NORMAL = 2'b00, CLS_ZERO = 2'b01, CLS_INF = 2'b10, CLS_NAN = 2'b11} cls_e;
  typedef enum logic [1:0] {RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RUP = 2'b10, RM_RDN = 2'b11} rmode_e;

  localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
  localparam logic [EXP_W-1:0]        EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [FRAC_W-1:0]       FRAC_ONES = '1;
  localparam logic [FRAC_W-1:0]       FRAC_QNAN = {1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [XW-1:0]    EXP_MAX   = XW'((1 << EXP_W) - 2);
  localparam logic signed [XW-1:0]    EXP_MIN   = XW'(1);

  logic stall;
  logic advance;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  // Forced high while in reset so upstream never sees a stall from stale output state.
  assign in_ready = ~rst_n | advance;

  // ---------------- Stage 1: increment and fraction add ----------------
  logic              grs;
  logic              inc;
  logic [FRAC_W:0]   frac_sum;

  assign grs = in_guard | in_round | in_sticky;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first,
  // so no latch is inferred when a case arm leaves a signal untouched.
  always_comb begin
    inc = 1'b0;
    case (rmode_e'(in_rmode))
      RM_RNE: inc = in_guard & (in_frac[0] | in_round | in_sticky);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = ~in_sign & grs;
      RM_RDN: inc = in_sign & grs;
      default: inc = 1'b0;
    endcase
  end

  assign frac_sum = {1'b0, in_frac} + {{FRAC_W{1'b0}}, inc};

  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W+1:0]  s1_exp;
  logic [FRAC_W:0]   s1_frac_sum;
  logic              s1_grs;
  cls_e              s1_class;
  rmode_e            s1_rmode;

  // NOTE: sequential state uses non-blocking '<='. Only the valid bits are reset; the payload
  // registers are qualified by valid and carry no reset, keeping the datapath flops cheap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_sign     <= in_sign;
      s1_exp      <= in_exp;
      s1_frac_sum <= frac_sum;
      s1_grs      <= grs;
      s1_class    <= cls_e'(in_class);
      s1_rmode    <= rmode_e'(in_rmode);
    end
  end

  // ---------------- Stage 2: exponent adjust, range check, pack ----------------
  logic                     carry;
  logic [FRAC_W-1:0]        frac_r;
  logic signed [XW-1:0]     exp_r;
  logic                     ovf;
  logic                     unf;
  logic                     to_inf;
  logic [EXP_W+FRAC_W:0]    res_data;
  logic [2:0]               res_flags;

  assign carry  = s1_frac_sum[FRAC_W];
  assign frac_r = carry ? '0 : s1_frac_sum[FRAC_W-1:0];
  assign exp_r  = $signed({s1_exp[EXP_W+1], s1_exp}) + $signed({{(XW-1){1'b0}}, carry});
  assign ovf    = exp_r > EXP_MAX;
  assign unf    = exp_r < EXP_MIN;

  // Overflow saturates to infinity only when the rounding direction points away from zero.
  assign to_inf = (s1_rmode == RM_RNE) ||
                  (s1_rmode == RM_RUP && !s1_sign) ||
                  (s1_rmode == RM_RDN && s1_sign);

  always_comb begin
    res_data  = '0;
    res_flags = '0;
    case (s1_class)
      CLS_ZERO: res_data = {s1_sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
      CLS_INF:  res_data = {s1_sign, EXP_ONES, {FRAC_W{1'b0}}};
      CLS_NAN:  res_data = {1'b0, EXP_ONES, FRAC_QNAN};
      default: begin
        if (ovf) begin
          res_flags = 3'b101;
          res_data  = to_inf ? {s1_sign, EXP_ONES, {FRAC_W{1'b0}}}
                             : {s1_sign, EXP_MAXF, FRAC_ONES};
        end else if (unf) begin
          res_flags = 3'b011;
          res_data  = {s1_sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
        end else begin
          res_flags = {2'b00, s1_grs};
          res_data  = {s1_sign, exp_r[EXP_W-1:0], frac_r};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= res_data;
        out_flags <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack_pipe.sv
// Directed bench for fp_round_pack_pipe (single precision): rounding modes, range limits,
// special classes, backpressure ordering and mid-flight reset.
module tb_fp_round_pack_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [22:0] in_frac;
  logic        in_guard, in_round, in_sticky;
  logic [1:0]  in_class;
  logic [1:0]  in_rmode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int errors = 0;
  int checks = 0;
  logic [31:0] retired[$];

  always #5 clk = ~clk;

  fp_round_pack_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
    .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
    .in_class(in_class), .in_rmode(in_rmode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) retired.push_back(out_data);

  task automatic set_beat(input logic s, input logic [9:0] e, input logic [22:0] f,
                          input logic [2:0] grs, input logic [1:0] cls, input logic [1:0] rm);
    in_sign = s; in_exp = e; in_frac = f;
    {in_guard, in_round, in_sticky} = grs;
    in_class = cls; in_rmode = rm;
  endtask

  // Accept one beat on an idle pipe and sample the result one edge after the accepting edge.
  task automatic run_beat(input logic s, input logic [9:0] e, input logic [22:0] f,
                          input logic [2:0] grs, input logic [1:0] cls, input logic [1:0] rm,
                          output logic v, output logic [31:0] d, output logic [2:0] fl);
    @(negedge clk);
    set_beat(s, e, f, grs, cls, rm);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v = out_valid; d = out_data; fl = out_flags;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_beat(1'b0, 10'd0, 23'd0, 3'b000, 2'b00, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", out_data); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", out_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_rounding;
    logic v; logic [31:0] d; logic [2:0] fl;
    // RNE with carry into exponent
    run_beat(1'b0, 10'd127, 23'h7FFFFF, 3'b100, 2'b00, 2'b00, v, d, fl);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL carry_latency got=%b exp=1", v); end
    checks++; if (d !== 32'h40000000) begin errors++; $display("FAIL carry_data got=%h exp=40000000", d); end
    checks++; if (fl !== 3'b001) begin errors++; $display("FAIL carry_flags got=%b exp=001", fl); end
    // RNE tie, even LSB stays
    run_beat(1'b0, 10'd127, 23'h000000, 3'b100, 2'b00, 2'b00, v, d, fl);
    checks++; if (d !== 32'h3F800000) begin errors++; $display("FAIL tie_even_data got=%h exp=3f800000", d); end
    checks++; if (fl !== 3'b001) begin errors++; $display("FAIL tie_even_flags got=%b exp=001", fl); end
    // RNE tie, odd LSB rounds up
    run_beat(1'b0, 10'd127, 23'h000001, 3'b100, 2'b00, 2'b00, v, d, fl);
    checks++; if (d !== 32'h3F800002) begin errors++; $display("FAIL tie_odd_data got=%h exp=3f800002", d); end
    // Exact result: no inexact
    run_beat(1'b0, 10'd130, 23'h200000, 3'b000, 2'b00, 2'b00, v, d, fl);
    checks++; if (d !== 32'h41200000) begin errors++; $display("FAIL exact_data got=%h exp=41200000", d); end
    checks++; if (fl !== 3'b000) begin errors++; $display("FAIL exact_flags got=%b exp=000", fl); end
    // RUP on negative truncates, RDN on negative rounds up in magnitude
    run_beat(1'b1, 10'd127, 23'h000010, 3'b001, 2'b00, 2'b10, v, d, fl);
    checks++; if (d !== 32'hBF800010) begin errors++; $display("FAIL rup_neg_data got=%h exp=bf800010", d); end
    run_beat(1'b1, 10'd127, 23'h000010, 3'b001, 2'b00, 2'b11, v, d, fl);
    checks++; if (d !== 32'hBF800011) begin errors++; $display("FAIL rdn_neg_data got=%h exp=bf800011", d); end
    // RTZ never increments
    run_beat(1'b0, 10'd127, 23'h000010, 3'b111, 2'b00, 2'b01, v, d, fl);
    checks++; if (d !== 32'h3F800010) begin errors++; $display("FAIL rtz_data got=%h exp=3f800010", d); end
  endtask

  task automatic test_range;
    logic v; logic [31:0] d; logic [2:0] fl;
    run_beat(1'b0, 10'd255, 23'h000000, 3'b000, 2'b00, 2'b01, v, d, fl);
    checks++; if (d !== 32'h7F7FFFFF) begin errors++; $display("FAIL ovf_rtz_data got=%h exp=7f7fffff", d); end
    checks++; if (fl !== 3'b101) begin errors++; $display("FAIL ovf_rtz_flags got=%b exp=101", fl); end
    run_beat(1'b0, 10'd255, 23'h000000, 3'b000, 2'b00, 2'b00, v, d, fl);
    checks++; if (d !== 32'h7F800000) begin errors++; $display("FAIL ovf_rne_data got=%h exp=7f800000", d); end
    run_beat(1'b1, 10'd255, 23'h000000, 3'b000, 2'b00, 2'b10, v, d, fl);
    checks++; if (d !== 32'hFF7FFFFF) begin errors++; $display("FAIL ovf_rup_neg_data got=%h exp=ff7fffff", d); end
    run_beat(1'b1, 10'd255, 23'h000000, 3'b000, 2'b00, 2'b11, v, d, fl);
    checks++; if (d !== 32'hFF800000) begin errors++; $display("FAIL ovf_rdn_neg_data got=%h exp=ff800000", d); end
    // Largest finite exponent stays in range
    run_beat(1'b0, 10'd254, 23'h7FFFFF, 3'b000, 2'b00, 2'b00, v, d, fl);
    checks++; if (d !== 32'h7F7FFFFF || fl !== 3'b000) begin errors++; $display("FAIL max_finite got=%h/%b exp=7f7fffff/000", d, fl); end
    // Rounding carry pushes 254 into overflow
    run_beat(1'b0, 10'd254, 23'h7FFFFF, 3'b110, 2'b00, 2'b00, v, d, fl);
    checks++; if (d !== 32'h7F800000 || fl !== 3'b101) begin errors++; $display("FAIL carry_ovf got=%h/%b exp=7f800000/101", d, fl); end
    run_beat(1'b1, 10'd0, 23'h123456, 3'b000, 2'b00, 2'b00, v, d, fl);
    checks++; if (d !== 32'h80000000) begin errors++; $display("FAIL unf_data got=%h exp=80000000", d); end
    checks++; if (fl !== 3'b011) begin errors++; $display("FAIL unf_flags got=%b exp=011", fl); end
    // Negative two's complement exponent underflows
    run_beat(1'b0, 10'h3F6, 23'h000001, 3'b000, 2'b00, 2'b00, v, d, fl);
    checks++; if (d !== 32'h00000000 || fl !== 3'b011) begin errors++; $display("FAIL unf_neg_exp got=%h/%b exp=00000000/011", d, fl); end
  endtask

  task automatic test_classes;
    logic v; logic [31:0] d; logic [2:0] fl;
    run_beat(1'b1, 10'd77, 23'h123456, 3'b111, 2'b11, 2'b00, v, d, fl);
    checks++; if (d !== 32'h7FC00000) begin errors++; $display("FAIL nan_data got=%h exp=7fc00000", d); end
    checks++; if (fl !== 3'b000) begin errors++; $display("FAIL nan_flags got=%b exp=000", fl); end
    run_beat(1'b1, 10'd300, 23'h7FFFFF, 3'b111, 2'b10, 2'b01, v, d, fl);
    checks++; if (d !== 32'hFF800000 || fl !== 3'b000) begin errors++; $display("FAIL inf_class got=%h/%b exp=ff800000/000", d, fl); end
    run_beat(1'b1, 10'd0, 23'h000000, 3'b101, 2'b01, 2'b00, v, d, fl);
    checks++; if (d !== 32'h80000000 || fl !== 3'b000) begin errors++; $display("FAIL zero_class got=%h/%b exp=80000000/000", d, fl); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q[3];
    exp_q[0] = 32'h3F800002;  // A: RNE tie with odd LSB
    exp_q[1] = 32'h40000000;  // B: RTZ drops guard bit
    exp_q[2] = 32'h40C00001;  // C: RUP positive with sticky
    repeat (3) @(negedge clk);
    retired.delete();
    out_ready = 1'b0;
    set_beat(1'b0, 10'd127, 23'h000001, 3'b100, 2'b00, 2'b00);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    set_beat(1'b0, 10'd128, 23'h000000, 3'b100, 2'b00, 2'b01);
    @(posedge clk); @(negedge clk);
    set_beat(1'b0, 10'd129, 23'h400000, 3'b001, 2'b00, 2'b10);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
      checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, out_data, exp_q[0]); end
      if (i < 2) begin @(posedge clk); @(negedge clk); end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (retired.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", retired.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < retired.size()) begin
        checks++; if (retired[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, retired[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_flight;
    @(negedge clk);
    out_ready = 1'b0;
    set_beat(1'b0, 10'd127, 23'h000000, 3'b000, 2'b00, 2'b00);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    set_beat(1'b0, 10'd128, 23'h000000, 3'b000, 2'b00, 2'b00);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL midrst_data got=%h exp=00000000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    retired.delete();
    repeat (6) @(negedge clk);
    checks++; if (retired.size() != 0) begin errors++; $display("FAIL midrst_stale got=%0d exp=0", retired.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_range();
    test_classes();
    test_back_to_back();
    test_reset_mid_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
